// File: rtl/sha_req_arbiter_pkg.sv
// Shared types and constants for the SHA-256 request arbiter.
package sha_arb_pkg;

  localparam int SHA_BLOCK_W     = 512;
  localparam int SHA_DIG_W       = 256;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } arb_state_e;

endpackage

// File: rtl/sha_req_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts at the index after ptr
// and returns the first active request as one-hot plus binary index.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        idx                          = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sha_req_arbiter.sv
// Shares one SHA-256 core among NREQ requesters, locking the core for a whole
// multi-block message. Define SHA_ARB_TIMEOUT_EN to add the digest watchdog.
module sha_req_arbiter
  import sha_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_last,
  input  logic [NREQ*SHA_BLOCK_W-1:0] req_block,
  output logic [NREQ-1:0]             req_grant,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [SHA_DIG_W-1:0]        rsp_digest,
  output logic [SHA_BLOCK_W-1:0]      sha_block,
  output logic                        sha_init,
  output logic                        sha_next,
  input  logic                        sha_ready,
  input  logic                        sha_digest_valid,
  input  logic [SHA_DIG_W-1:0]        sha_digest,
  output logic                        busy
`ifdef SHA_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("sha_req_arbiter: NREQ or TIMEOUT_CYC out of range");
  end

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic [NREQ-1:0]        grant_d, rsp_valid_d;
  logic                   init_d, next_d;
  logic [SHA_BLOCK_W-1:0] block_d;
  logic [SHA_DIG_W-1:0]   digest_d;

  logic [NREQ-1:0]        pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NREQ-1:0]        win_onehot;

  rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign win_onehot = NREQ'(1) << winner_q;
  assign busy       = (state_q != IDLE);

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    last_d      = last_q;
    grant_d     = '0;
    init_d      = 1'b0;
    next_d      = 1'b0;
    block_d     = sha_block;
    rsp_valid_d = '0;
    digest_d    = rsp_digest;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          winner_d = pick_idx;
          first_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // A locked winner that drops req_valid simply stalls the core here.
        if (sha_ready && req_valid[winner_q]) begin
          grant_d = win_onehot;
          init_d  = first_q;
          next_d  = !first_q;
          block_d = req_block[int'(winner_q)*SHA_BLOCK_W +: SHA_BLOCK_W];
          last_d  = req_last[winner_q];
          first_d = 1'b0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!sha_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sha_ready && sha_digest_valid) begin
          if (last_q) begin
            digest_d    = sha_digest;
            rsp_valid_d = win_onehot;
            state_d     = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      RESP: begin
        ptr_d   = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SHA_ARB_TIMEOUT_EN
    tmo_cnt_d = '0;
    tmo_err_d = 1'b0;
    if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_err_d   = 1'b1;
        ptr_d       = winner_q;
        rsp_valid_d = '0;
        digest_d    = rsp_digest;
        state_d     = IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      ptr_q      <= IDX_W'(NREQ - 1);
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      req_grant  <= '0;
      rsp_valid  <= '0;
      sha_init   <= 1'b0;
      sha_next   <= 1'b0;
      // NOTE: wide data registers are reset too because they drive visible outputs.
      sha_block  <= '0;
      rsp_digest <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      req_grant  <= grant_d;
      rsp_valid  <= rsp_valid_d;
      sha_init   <= init_d;
      sha_next   <= next_d;
      sha_block  <= block_d;
      rsp_digest <= digest_d;
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_err <= tmo_err_d;
    end
  end
`endif

endmodule
